// File: rtl/tinysoc_pkg.sv
// Shared tinysoc definitions: sequencer state codes, pin beat width and
// instruction word width. Used by the sequencer, the CPU and the top level.
package tinysoc_pkg;

    localparam int unsigned TS_BEAT_W  = 6;
    localparam int unsigned TS_INSTR_W = 2 * TS_BEAT_W;

    typedef enum logic [2:0] {
        SEQ_IDLE = 3'd0,
        SEQ_LOAD = 3'd1,
        SEQ_HALT = 3'd2,
        SEQ_RUN  = 3'd3,
        SEQ_STEP = 3'd4
    } seq_state_e;

endpackage

// File: rtl/pin_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous io pin.
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active-high
//   pin  - asynchronous input pin
//   rise - one-cycle pulse, two clocks after the pin rises
module pin_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/soc_run_sequencer.sv
// Boot-and-run controller for the tinysoc CPU. Streams a program into the
// instruction memory as pairs of pin beats, then owns CPU enable/reset for
// free run, single step, halt and budgeted run.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   load_data         - program beat from pins
//   load_strobe       - async pin, each rising edge presents one beat
//   load_start        - pulse, begin (re)load from IDLE or HALT
//   run_req/step_req/halt_req - control pulses
//   run_limit         - RUN cycle budget, 0 = unlimited
//   imem_waddr/imem_wdata/imem_wr - instruction memory write port
//   cpu_en, cpu_rst   - CPU enable and synchronous reset
//   load_done         - program image complete
//   state             - FSM state code for debug pins
module soc_run_sequencer
    import tinysoc_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 8,
    parameter int unsigned IADDR_W    = 3,
    parameter int unsigned BEAT_W     = TS_BEAT_W,
    parameter int unsigned CYCLE_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BEAT_W-1:0]     load_data,
    input  logic                  load_strobe,
    input  logic                  load_start,
    input  logic                  run_req,
    input  logic                  step_req,
    input  logic                  halt_req,
    input  logic [CYCLE_W-1:0]    run_limit,
    output logic [IADDR_W-1:0]    imem_waddr,
    output logic [2*BEAT_W-1:0]   imem_wdata,
    output logic                  imem_wr,
    output logic                  cpu_en,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic [2:0]            state
);

    localparam logic [IADDR_W-1:0] LastAddr = IADDR_W'(IMEM_DEPTH - 1);

    seq_state_e            state_q;
    logic [IADDR_W-1:0]    addr_q;
    logic [2*BEAT_W-1:0]   wdata_q;
    logic                  wr_q;
    logic                  en_q;
    logic                  crst_q;
    logic                  done_q;
    logic                  phase_q;
    logic [BEAT_W-1:0]     low_q;
    logic [CYCLE_W-1:0]    cycle_cnt_q;

    logic                  beat;
    logic [CYCLE_W-1:0]    cnt_inc;
    logic                  budget_hit;

    pin_edge_sync u_strobe_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (load_strobe),
        .rise (beat)
    );

    assign cnt_inc    = cycle_cnt_q + CYCLE_W'(1);
    assign budget_hit = (run_limit != '0) && (cnt_inc == run_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEQ_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            en_q        <= 1'b0;
            crst_q      <= 1'b1;
            done_q      <= 1'b0;
            phase_q     <= 1'b0;
            low_q       <= '0;
            cycle_cnt_q <= '0;
        end else begin
            wr_q <= 1'b0;
            // Address advances the cycle after each write strobe.
            if (wr_q) begin
                addr_q <= addr_q + IADDR_W'(1);
            end
            unique case (state_q)
                SEQ_IDLE: begin
                    crst_q <= 1'b1;
                    en_q   <= 1'b0;
                    if (load_start) begin
                        state_q <= SEQ_LOAD;
                        done_q  <= 1'b0;
                        addr_q  <= '0;
                        phase_q <= 1'b0;
                    end
                end
                SEQ_LOAD: begin
                    crst_q <= 1'b1;
                    en_q   <= 1'b0;
                    if (wr_q && (addr_q == LastAddr)) begin
                        state_q <= SEQ_HALT;
                        done_q  <= 1'b1;
                    end else if (beat) begin
                        if (!phase_q) begin
                            low_q   <= load_data;
                            phase_q <= 1'b1;
                        end else begin
                            wr_q    <= 1'b1;
                            wdata_q <= {load_data, low_q};
                            phase_q <= 1'b0;
                        end
                    end
                end
                SEQ_HALT: begin
                    // cpu_rst stays high only for the first HALT cycle after LOAD.
                    crst_q <= 1'b0;
                    en_q   <= 1'b0;
                    if (load_start) begin
                        state_q <= SEQ_LOAD;
                        crst_q  <= 1'b1;
                        done_q  <= 1'b0;
                        addr_q  <= '0;
                        phase_q <= 1'b0;
                    end else if (halt_req) begin
                        state_q <= SEQ_HALT;
                    end else if (step_req) begin
                        state_q <= SEQ_STEP;
                        en_q    <= 1'b1;
                    end else if (run_req) begin
                        state_q     <= SEQ_RUN;
                        en_q        <= 1'b1;
                        cycle_cnt_q <= '0;
                    end
                end
                SEQ_STEP: begin
                    en_q    <= 1'b0;
                    state_q <= SEQ_HALT;
                end
                SEQ_RUN: begin
                    if (cycle_cnt_q != '1) begin
                        cycle_cnt_q <= cnt_inc;
                    end
                    // load_start here only halts; the load needs a second pulse.
                    if (halt_req || load_start || budget_hit) begin
                        state_q <= SEQ_HALT;
                        en_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= SEQ_IDLE;
                    en_q    <= 1'b0;
                    crst_q  <= 1'b1;
                end
            endcase
        end
    end

    assign imem_waddr = addr_q;
    assign imem_wdata = wdata_q;
    assign imem_wr    = wr_q;
    assign cpu_en     = en_q;
    assign cpu_rst    = crst_q;
    assign load_done  = done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_soc_run_sequencer.sv
module tb_soc_run_sequencer;
    import tinysoc_pkg::*;

    localparam int unsigned AW = 3;
    localparam int unsigned BW = TS_BEAT_W;
    localparam int unsigned CW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [BW-1:0]     load_data;
    logic              load_strobe;
    logic              load_start;
    logic              run_req;
    logic              step_req;
    logic              halt_req;
    logic [CW-1:0]     run_limit;
    logic [AW-1:0]     imem_waddr;
    logic [2*BW-1:0]   imem_wdata;
    logic              imem_wr;
    logic              cpu_en;
    logic              cpu_rst;
    logic              load_done;
    logic [2:0]        state;

    soc_run_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .load_data   (load_data),
        .load_strobe (load_strobe),
        .load_start  (load_start),
        .run_req     (run_req),
        .step_req    (step_req),
        .halt_req    (halt_req),
        .run_limit   (run_limit),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .imem_wr     (imem_wr),
        .cpu_en      (cpu_en),
        .cpu_rst     (cpu_rst),
        .load_done   (load_done),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [2*BW-1:0] data;
    } wr_t;

    wr_t             exp_q[$];
    int              checks = 0;
    int              failures = 0;
    int              en_cycles = 0;
    int              wr_seen = 0;
    logic [AW-1:0]   m_addr = '0;
    logic [BW-1:0]   m_low = '0;
    logic            m_phase = 1'b0;
    logic            m_loading = 1'b0;

    // One clock; sample #1 after the edge and score any imem write.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (cpu_en) en_cycles++;
        if (imem_wr) begin
            wr_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL imem_wr_unexpected: got addr=%0d data=%h, required no write",
                         imem_waddr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (imem_waddr !== e.addr || imem_wdata !== e.data) begin
                    failures++;
                    $display("FAIL imem_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             imem_waddr, imem_wdata, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic drive_reqs(input logic ls, input logic hr, input logic sr, input logic rr);
        load_start = ls;
        halt_req   = hr;
        step_req   = sr;
        run_req    = rr;
        tick();
        load_start = 1'b0;
        halt_req   = 1'b0;
        step_req   = 1'b0;
        run_req    = 1'b0;
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input int low_ticks);
        load_data   = d;
        load_strobe = 1'b1;
        if (m_loading) begin
            if (!m_phase) begin
                m_low   = d;
                m_phase = 1'b1;
            end else begin
                exp_q.push_back('{addr: m_addr, data: {d, m_low}});
                m_addr  = m_addr + AW'(1);
                m_phase = 1'b0;
            end
        end
        repeat (3) tick();
        load_strobe = 1'b0;
        repeat (low_ticks) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({state, imem_wr, cpu_en, cpu_rst, load_done, imem_waddr, imem_wdata} !==
            {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, {AW{1'b0}}, {2*BW{1'b0}}}) begin
            failures++;
            $display("FAIL reset_state: got st=%0d wr=%b en=%b crst=%b done=%b a=%0d d=%h, required 0 0 0 1 0 0 000",
                     state, imem_wr, cpu_en, cpu_rst, load_done, imem_waddr, imem_wdata);
        end
        rst = 1'b0;
        tick();
        drive_reqs(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checks++;
        if ({state, cpu_en, cpu_rst} !== {3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL idle_ignores_req: got st=%0d en=%b crst=%b, required st=0 en=0 crst=1",
                     state, cpu_en, cpu_rst);
        end
    endtask

    task automatic test_load(input logic [BW-1:0] base);
        m_loading = 1'b1;
        m_addr    = '0;
        m_phase   = 1'b0;
        drive_reqs(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({state, load_done, cpu_rst, cpu_en} !== {3'd1, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL load_entry: got st=%0d done=%b crst=%b en=%b, required 1 0 1 0",
                     state, load_done, cpu_rst, cpu_en);
        end
        for (int i = 0; i < 16; i++) begin
            send_beat(base + BW'(i), (i == 15) ? 0 : 3);
        end
        // Now in the cycle of the final write.
        checks++;
        if ({state, load_done} !== {3'd1, 1'b0}) begin
            failures++;
            $display("FAIL load_last_write: got st=%0d done=%b, required st=1 done=0", state, load_done);
        end
        tick();
        checks++;
        if ({state, load_done, cpu_rst, imem_wr} !== {3'd2, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL load_to_halt: got st=%0d done=%b crst=%b wr=%b, required 2 1 1 0",
                     state, load_done, cpu_rst, imem_wr);
        end
        tick();
        checks++;
        if ({state, load_done, cpu_rst} !== {3'd2, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL halt_cpu_rst_once: got st=%0d done=%b crst=%b, required 2 1 0",
                     state, load_done, cpu_rst);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL load_write_count: got %0d writes missing, required 0", exp_q.size());
        end
        m_loading = 1'b0;
    endtask

    task automatic test_step();
        en_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            drive_reqs(1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if ({state, cpu_en} !== {3'd4, 1'b1}) begin
                failures++;
                $display("FAIL step_active: got st=%0d en=%b, required st=4 en=1", state, cpu_en);
            end
            tick();
            checks++;
            if ({state, cpu_en} !== {3'd2, 1'b0}) begin
                failures++;
                $display("FAIL step_return: got st=%0d en=%b, required st=2 en=0", state, cpu_en);
            end
            tick();
        end
        checks++;
        if (en_cycles != 3) begin
            failures++;
            $display("FAIL step_total: got %0d enabled cycles, required 3", en_cycles);
        end
    endtask

    task automatic test_run_limit();
        run_limit = CW'(5);
        en_cycles = 0;
        drive_reqs(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({state, cpu_en} !== {3'd3, 1'b1}) begin
            failures++;
            $display("FAIL run_entry: got st=%0d en=%b, required st=3 en=1", state, cpu_en);
        end
        repeat (10) tick();
        checks++;
        if (en_cycles != 5 || state !== 3'd2 || dut.cycle_cnt_q !== CW'(5)) begin
            failures++;
            $display("FAIL run_budget: got en_cycles=%0d st=%0d cnt=%0d, required 5 2 5",
                     en_cycles, state, dut.cycle_cnt_q);
        end
    endtask

    task automatic test_run_unlimited();
        run_limit = '0;
        en_cycles = 0;
        drive_reqs(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (19) tick();
        checks++;
        if (en_cycles != 20 || state !== 3'd3) begin
            failures++;
            $display("FAIL run_free: got en_cycles=%0d st=%0d, required 20 3", en_cycles, state);
        end
        drive_reqs(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (cpu_en !== 1'b0 || state !== 3'd2 || en_cycles != 20 || dut.cycle_cnt_q !== CW'(20)) begin
            failures++;
            $display("FAIL run_halt: got en=%b st=%0d en_cycles=%0d cnt=%0d, required 0 2 20 20",
                     cpu_en, state, en_cycles, dut.cycle_cnt_q);
        end
        drive_reqs(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (cpu_en !== 1'b1 || dut.cycle_cnt_q !== '0) begin
            failures++;
            $display("FAIL run_resume: got en=%b cnt=%0d, required en=1 cnt=0", cpu_en, dut.cycle_cnt_q);
        end
        drive_reqs(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_priority_and_strobe();
        drive_reqs(1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        checks++;
        if ({state, cpu_en} !== {3'd2, 1'b0}) begin
            failures++;
            $display("FAIL halt_priority: got st=%0d en=%b, required st=2 en=0", state, cpu_en);
        end
        m_loading = 1'b0;
        run_limit = '0;
        drive_reqs(1'b0, 1'b0, 1'b0, 1'b1);
        wr_seen = 0;
        for (int i = 0; i < 3; i++) send_beat(BW'(6'h2a + i), 3);
        checks++;
        if (wr_seen != 0 || state !== 3'd3) begin
            failures++;
            $display("FAIL strobe_in_run: got writes=%0d st=%0d, required 0 3", wr_seen, state);
        end
    endtask

    task automatic test_run_load_start();
        drive_reqs(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({state, cpu_en} !== {3'd2, 1'b0}) begin
            failures++;
            $display("FAIL run_load_start_halts: got st=%0d en=%b, required st=2 en=0", state, cpu_en);
        end
        drive_reqs(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({state, load_done, cpu_rst} !== {3'd1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL second_load_start: got st=%0d done=%b crst=%b, required 1 0 1",
                     state, load_done, cpu_rst);
        end
    endtask

    task automatic test_mid_load_reset();
        m_loading = 1'b1;
        m_addr    = '0;
        m_phase   = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(BW'(6'h31 + i), 3);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({state, imem_wr, cpu_en, cpu_rst, load_done, imem_waddr, imem_wdata} !==
            {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, {AW{1'b0}}, {2*BW{1'b0}}}) begin
            failures++;
            $display("FAIL async_reset: got st=%0d wr=%b en=%b crst=%b done=%b a=%0d d=%h, required 0 0 0 1 0 0 000",
                     state, imem_wr, cpu_en, cpu_rst, load_done, imem_waddr, imem_wdata);
        end
        exp_q.delete();
        rst = 1'b0;
        tick();
        test_load(BW'(6'h20));
    endtask

    initial begin
        rst         = 1'b1;
        load_data   = '0;
        load_strobe = 1'b0;
        load_start  = 1'b0;
        run_req     = 1'b0;
        step_req    = 1'b0;
        halt_req    = 1'b0;
        run_limit   = '0;
        test_reset();
        test_load(BW'(6'h01));
        test_step();
        test_run_limit();
        test_run_unlimited();
        test_priority_and_strobe();
        test_run_load_start();
        test_mid_load_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
